// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// Module   : alu_seq_ctrl
// Brief    : Sequencer for the shared ripple ALU: single-pass logic/arith ops
//            and an unsigned shift-add multiply built on the ALU adder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_ctrl #(
    parameter int MUL_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] res,
    output logic        zero_f,
    output logic        ovr_f,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    output logic        alu_binv,
    output logic        alu_sel1,
    output logic        alu_sel0,
    input  logic [31:0] alu_result,
    input  logic        alu_ovr
);

    localparam int CNT_W = (MUL_W > 1) ? $clog2(MUL_W) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MUL_W - 1);

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_SUB  = 3'b011;
    localparam logic [2:0] c_OP_SLT  = 3'b100;
    localparam logic [2:0] c_OP_MULU = 3'b101;

    // {sel1, sel0, binv, cin}
    localparam logic [3:0] c_CTRL_AND = 4'b0000;
    localparam logic [3:0] c_CTRL_OR  = 4'b0100;
    localparam logic [3:0] c_CTRL_ADD = 4'b1000;
    localparam logic [3:0] c_CTRL_SUB = 4'b1011;
    localparam logic [3:0] c_CTRL_SLT = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [3:0] op_ctrl(input logic [2:0] o);
        logic [3:0] c;
        case (o)
            c_OP_AND: c = c_CTRL_AND;
            c_OP_OR:  c = c_CTRL_OR;
            c_OP_SUB: c = c_CTRL_SUB;
            c_OP_SLT: c = c_CTRL_SLT;
            default:  c = c_CTRL_ADD;
        endcase
        return c;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       m_q, m_d;
    logic [MUL_W-1:0]  q_q, q_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       res_q, res_d;
    logic              zero_q, zero_d;
    logic              ovr_q, ovr_d;
    logic [31:0]       alu_a_q, alu_a_d;
    logic [31:0]       alu_b_q, alu_b_d;
    logic [3:0]        ctrl_q, ctrl_d;

    logic              w_op_legal;
    assign w_op_legal = (op <= c_OP_MULU);

    // ALU drive is registered one cycle ahead; alu_a_q doubles as the product accumulator P
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        m_d     = m_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        zero_d  = zero_q;
        ovr_d   = ovr_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        ctrl_d  = ctrl_q;

        case (state_q)
            S_IDLE: begin
                if (start && w_op_legal) begin
                    op_d   = op;
                    busy_d = 1'b1;
                    if (op == c_OP_MULU) begin
                        m_d     = 32'(opb[MUL_W-1:0]);
                        q_d     = opa[MUL_W-1:0];
                        cnt_d   = '0;
                        alu_a_d = '0;
                        alu_b_d = opa[0] ? 32'(opb[MUL_W-1:0]) : '0;
                        ctrl_d  = c_CTRL_ADD;
                        state_d = S_MUL;
                    end else begin
                        alu_a_d = opa;
                        alu_b_d = opb;
                        ctrl_d  = op_ctrl(op);
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                res_d   = alu_result;
                zero_d  = (alu_result == 32'd0);
                ovr_d   = ((op_q == c_OP_ADD) || (op_q == c_OP_SUB)) && alu_ovr;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_MUL: begin
                m_d     = m_q << 1;
                q_d     = q_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                alu_a_d = alu_result;
                // Next partial product uses the multiplier bit that shifts into Q[0]
                alu_b_d = q_q[1] ? (m_q << 1) : '0;
                if (cnt_q == c_CNT_LAST) begin
                    res_d   = alu_result;
                    zero_d  = (alu_result == 32'd0);
                    ovr_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            m_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ovr_q   <= 1'b0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            m_q     <= m_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovr_q   <= ovr_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign res      = res_q;
    assign zero_f   = zero_q;
    assign ovr_f    = ovr_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel1 = ctrl_q[3];
    assign alu_sel0 = ctrl_q[2];
    assign alu_binv = ctrl_q[1];
    assign alu_cin  = ctrl_q[0];

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Brief    : Self-checking bench for alu_seq_ctrl with a behavioural ALU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic        busy, done, zero_f, ovr_f;
    logic [31:0] res, alu_a, alu_b, alu_result;
    logic        alu_cin, alu_binv, alu_sel1, alu_sel0, alu_ovr;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq_ctrl #(.MUL_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .res(res), .zero_f(zero_f), .ovr_f(ovr_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_binv(alu_binv),
        .alu_sel1(alu_sel1), .alu_sel0(alu_sel0),
        .alu_result(alu_result), .alu_ovr(alu_ovr)
    );

    always #5 clk = ~clk;

    // Ripple-ALU stand-in: b-invert, carry-in, and a 4-way result mux
    logic [31:0] w_bb, w_sum;
    always_comb begin
        w_bb       = alu_binv ? ~alu_b : alu_b;
        w_sum      = alu_a + w_bb + {31'b0, alu_cin};
        alu_ovr    = (alu_a[31] == w_bb[31]) && (w_sum[31] != alu_a[31]);
        alu_result = 32'd0;
        case ({alu_sel1, alu_sel0})
            2'b00:   alu_result = alu_a & w_bb;
            2'b01:   alu_result = alu_a | w_bb;
            2'b10:   alu_result = w_sum;
            default: alu_result = {31'b0, w_sum[31] ^ alu_ovr};
        endcase
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        v;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] enc(input logic [2:0] o);
        case (o)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0100;
            3'd3:    return 4'b1011;
            3'd4:    return 4'b1111;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic v);
        v = 1'b0;
        case (o)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                r = a + b;
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd3: begin
                r = a - b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = {16'b0, a[15:0]} * {16'b0, b[15:0]};
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r_exp, input logic z_exp, input logic v_exp,
                          input string tag);
        int cyc;
        int busy_cyc;
        start = 1'b1; op = o; opa = a; opb = b;
        tick();
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        opa   = $urandom;
        opb   = $urandom;
        cyc      = 1;
        busy_cyc = 0;
        if (o != 3'd5) begin
            chk({tag, "_alu_a"}, alu_a, a);
            chk({tag, "_alu_b"}, alu_b, b);
            chk({tag, "_alu_ctrl"}, {28'b0, alu_sel1, alu_sel0, alu_binv, alu_cin}, {28'b0, enc(o)});
        end
        while (!done && cyc < 40) begin
            if (busy) busy_cyc++;
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), (o == 3'd5) ? 32'd17 : 32'd2);
        chk({tag, "_busy_cycles"}, 32'(busy_cyc), (o == 3'd5) ? 32'd16 : 32'd1);
        chk({tag, "_res"}, res, r_exp);
        chk({tag, "_zero"}, {31'b0, zero_f}, {31'b0, z_exp});
        chk({tag, "_ovr"}, {31'b0, ovr_f}, {31'b0, v_exp});
        chk({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_res_hold"}, res, r_exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic        v;
        logic [2:0]  o;
        logic [31:0] a, b;
        int          cyc, ndone, done_at, bad;

        tbl[0]  = '{3'd2, 32'd5,        32'd7,        32'h0000000C, 1'b0, 1'b0};
        tbl[1]  = '{3'd3, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1};
        tbl[2]  = '{3'd3, 32'd3,        32'd3,        32'h00000000, 1'b1, 1'b0};
        tbl[3]  = '{3'd4, 32'hFFFFFFFE, 32'd1,        32'h00000001, 1'b0, 1'b0};
        tbl[4]  = '{3'd4, 32'd1,        32'hFFFFFFFE, 32'h00000000, 1'b1, 1'b0};
        tbl[5]  = '{3'd5, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b0, 1'b0};
        tbl[6]  = '{3'd5, 32'h00000000, 32'h00001234, 32'h00000000, 1'b1, 1'b0};
        tbl[7]  = '{3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        tbl[8]  = '{3'd1, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0};
        tbl[9]  = '{3'd2, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1};
        tbl[10] = '{3'd5, 32'hABCD0003, 32'h12340005, 32'h0000000F, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; op = 3'd0; opa = '0; opb = '0;
        repeat (3) tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_flags", {30'b0, zero_f, ovr_f}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ctrl", {28'b0, alu_sel1, alu_sel0, alu_binv, alu_cin}, 32'd0);
        rst = 1'b0;
        tick();

        foreach (tbl[i])
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].z, tbl[i].v, $sformatf("vec%0d", i));

        // Start pulsed mid-multiply must be ignored
        start = 1'b1; op = 3'd5; opa = 32'h00001234; opb = 32'h00000056;
        tick();
        cyc = 1; ndone = 0; done_at = 0;
        while (cyc < 30) begin
            if (cyc == 5) begin
                start = 1'b1; op = 3'd2; opa = 32'd1; opb = 32'd2;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = cyc;
            end
            tick();
            cyc++;
        end
        ref_model(3'd5, 32'h00001234, 32'h00000056, r, v);
        chk("busy_start_ndone", 32'(ndone), 32'd1);
        chk("busy_start_latency", 32'(done_at), 32'd17);
        chk("busy_start_res", res, r);

        // Illegal opcodes are dropped in IDLE
        for (int k = 6; k < 8; k++) begin
            start = 1'b1; op = 3'(k); opa = 32'd9; opb = 32'd9;
            tick();
            start = 1'b0;
            bad = 0;
            for (int j = 0; j < 5; j++) begin
                if (busy || done) bad++;
                tick();
            end
            chk($sformatf("illegal_op%0d", k), 32'(bad), 32'd0);
        end

        // Reset in the middle of a multiply aborts silently
        start = 1'b1; op = 3'd5; opa = 32'h0000FFFF; opb = 32'h0000FFFF;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("midrst_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_res", res, 32'd0);
        chk("midrst_alu_a", alu_a, 32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int j = 0; j < 20; j++) begin
            if (done) ndone++;
            tick();
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        run_op(3'd2, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, "post_rst_add");

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 5));
            a = $urandom;
            b = $urandom;
            if (n % 4 == 1) b = a;
            if (n % 4 == 2) a = {a[31], 31'h7FFFFFFF} ^ {32{b[0]}};
            ref_model(o, a, b, r, v);
            run_op(o, a, b, r, (r == 32'd0), v, $sformatf("rnd%0d_op%0d", n, o));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
